booth_seq_multiplier: RTL and testbench
=======================================

// Module: booth_seq_multiplier
// PURPOSE
//   Sequential radix-2 Booth multiplier for the MatrixMult datapath: multiplies two
//   signed two's-complement operands and delivers the exact full-width product.
//   Sits directly upstream of the multiplier rounding stage; prod_out feeds its
//   product input unchanged.
//   One multiply in flight; valid/ready handshake on both sides.
// PARAMETERS
//   WIDTH_IN    4             operand width, signed; must be >= 2
//   WIDTH_PROD  2*WIDTH_IN    product width (localparam; not overridable)
// PORTS
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous active-low reset
//   start_valid in   1           operand pair a_in/b_in valid
//   start_ready out  1           block can accept operands (high only in IDLE)
//   a_in        in   WIDTH_IN    multiplicand, signed
//   b_in        in   WIDTH_IN    multiplier, signed
//   prod_valid  out  1           prod_out holds a finished product
//   prod_ready  in   1           downstream takes prod_out
//   prod_out    out  WIDTH_PROD  signed product a_in*b_in
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE; start_ready=1 once rst_n high;
//     prod_valid=0; prod_out=0; internal accumulator/counter cleared.
//   States: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: start_ready=1. Edge with start_valid=1: latch a_in, b_in; load
//     A=0 (WIDTH_IN+1 bits), Q=b_in, q_-1=0, count=WIDTH_IN; go to BUSY.
//   BUSY: start_ready=0; start_valid ignored (no queuing). One Booth step per edge:
//     {Q0,q_-1}=01: A+=sext(a); 10: A-=sext(a); 00/11: no op; then arithmetic
//     right shift of {A,Q,q_-1}; count-=1. On the step making count 0, go to DONE
//     and load prod_out = low WIDTH_PROD bits of {A,Q}.
//   A is WIDTH_IN+1 bits so that subtracting a = -2^(WIDTH_IN-1) cannot overflow.
//   Latency: prod_valid rises exactly WIDTH_IN clocks after the accepting edge.
//   DONE: prod_valid=1; prod_out stable until the handshake.
//     Edge with prod_ready=1: prod_valid=0, state=IDLE. prod_out keeps its last
//     value; it is don't-care while prod_valid=0.
//     prod_ready=0: hold indefinitely (back-pressure).
//     A new start is accepted only from IDLE. Minimum issue interval is WIDTH_IN+2
//     clocks with prod_ready tied high.
//   prod_ready outside DONE: ignored.
//   Arithmetic: the product is exact for all operand pairs. For WIDTH_IN=4, the
//     result for (-2^(W-1))*(-2^(W-1)) is +2^(2W-2) = 8'h40. This is the only case
//     where bits [WIDTH_PROD-1] and [WIDTH_PROD-2] differ, and the downstream
//     rounding stage depends on it.
//   Reset asserted mid-BUSY or mid-DONE: immediately abort to IDLE with the reset
//     values above. No partial result is ever presented.
// TESTING (WIDTH_IN=4)
//   a=3, b=5, prod_ready=1 -> prod_valid exactly 4 clks after accept; prod_out=8'h0F.
//   a=-8, b=-8 -> prod_out=8'h40. Also check a=-8, b=7 -> 8'hC8; a=-3, b=5 -> 8'hF1;
//     a=0, b=-1 -> 8'h00.
//   Exhaustive sweep, 256 pairs, checked against $signed(a)*$signed(b) -> all match;
//     start_ready never high while BUSY or DONE.
//   Pulse start_valid with new operands during BUSY -> ignored; the first product
//     is still correct, and the second pair is accepted only after returning to IDLE.
//   Hold prod_ready=0 for 10 clks in DONE -> prod_valid=1 and prod_out constant;
//     raise prod_ready -> next edge prod_valid=0, start_ready=1.
//   Assert rst_n low at the 2nd BUSY cycle -> outputs reset asynchronously; the next
//     multiply, 7*7, yields 8'h31 with normal latency.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, one signed multiply in flight.
// Valid/ready on operand and product sides; WIDTH_IN Booth steps per multiply.
module booth_seq_multiplier #(
  parameter int WIDTH_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [WIDTH_IN-1:0]     a_in,
  input  logic [WIDTH_IN-1:0]     b_in,
  output logic                    prod_valid,
  input  logic                    prod_ready,
  output logic [2*WIDTH_IN-1:0]   prod_out
);

  localparam int WIDTH_PROD = 2 * WIDTH_IN;
  localparam int CW = $clog2(WIDTH_IN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH_IN-1:0]     a_q, a_d;
  logic [WIDTH_IN:0]       acc_q, acc_d;
  logic [WIDTH_IN-1:0]     q_q, q_d;
  logic                    qm1_q, qm1_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WIDTH_PROD-1:0]   prod_q, prod_d;

  logic [WIDTH_IN:0]       a_ext;
  logic [WIDTH_IN:0]       sum;
  logic [WIDTH_IN:0]       acc_sh;
  logic [WIDTH_IN-1:0]     q_sh;

  // A is one bit wider than a so that subtracting the most negative a fits.
  always_comb begin
    a_ext = {a_q[WIDTH_IN-1], a_q};
    sum   = acc_q;
    unique case (1'b1)
      ({q_q[0], qm1_q} == 2'b01): sum = acc_q + a_ext;
      ({q_q[0], qm1_q} == 2'b10): sum = acc_q - a_ext;
      default:                    sum = acc_q;
    endcase
    acc_sh = {sum[WIDTH_IN], sum[WIDTH_IN:1]};
    q_sh   = {sum[0], q_q[WIDTH_IN-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a_in;
          acc_d   = '0;
          q_d     = b_in;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH_IN);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prod_d  = {acc_sh[WIDTH_IN-1:0], q_sh};
          state_d = DONE;
        end
      end
      DONE: begin
        if (prod_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign prod_valid  = (state_q == DONE);
  assign prod_out    = prod_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier (WIDTH_IN=4): vectors, sweep, random, corners.
// Expected products come from constants or plain signed multiplication.
module tb_booth_seq_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_valid = 1'b0;
  logic           start_ready;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic           prod_valid;
  logic           prod_ready = 1'b0;
  logic [2*W-1:0] prod_out;

  int n_cmp = 0;
  int n_bad = 0;

  booth_seq_multiplier #(.WIDTH_IN(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .prod_valid  (prod_valid),
    .prod_ready  (prod_ready),
    .prod_out    (prod_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int pa, pb;
    pa = int'($signed(a));
    pb = int'($signed(b));
    return (2*W)'(pa * pb);
  endfunction

  // Issue one multiply from a negedge in IDLE, hold back-pressure for
  // hold cycles, then complete the product handshake.
  task automatic run_mul(input string nm,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic [2*W-1:0] exp,
                         input int hold);
    int lat;
    int bad_rdy;
    int bad_hold;
    logic [2*W-1:0] p;
    @(negedge clk);
    chk({nm, "_idle_ready"}, 32'(start_ready), 32'd1);
    a_in = a;
    b_in = b;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    lat = 0;
    bad_rdy = 0;
    while (!prod_valid && lat < 20) begin
      if (start_ready) bad_rdy++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(W));
    p = prod_out;
    chk({nm, "_prod"}, 32'(p), 32'(exp));
    bad_hold = 0;
    for (int i = 0; i < hold; i++) begin
      if (start_ready) bad_rdy++;
      @(negedge clk);
      if (!prod_valid || prod_out !== p) bad_hold++;
    end
    if (hold > 0) chk({nm, "_hold"}, 32'(bad_hold), 32'd0);
    chk({nm, "_busy_ready"}, 32'(bad_rdy), 32'd0);
    prod_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    prod_ready = 1'b0;
    chk({nm, "_ack_valid"}, 32'(prod_valid), 32'd0);
    chk({nm, "_ack_ready"}, 32'(start_ready), 32'd1);
  endtask

  vec_t vecs[6];
  int sweep_bad;
  int lat;
  logic [W-1:0] ra, rb;

  initial begin
    vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 8'h0F};
    vecs[1] = '{a: 4'h8,  b: 4'h8,  p: 8'h40};
    vecs[2] = '{a: 4'h8,  b: 4'd7,  p: 8'hC8};
    vecs[3] = '{a: 4'hD,  b: 4'd5,  p: 8'hF1};
    vecs[4] = '{a: 4'd0,  b: 4'hF,  p: 8'h00};
    vecs[5] = '{a: 4'd7,  b: 4'd7,  p: 8'h31};

    #12;
    chk("rst_valid", 32'(prod_valid), 32'd0);
    chk("rst_prod", 32'(prod_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(start_ready), 32'd1);

    for (int i = 0; i < 6; i++)
      run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, 0);

    // Exhaustive sweep folded into one comparison per field.
    sweep_bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!start_ready) sweep_bad++;
      a_in = 4'(i >> 4);
      b_in = 4'(i);
      start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
      prod_ready = 1'b1;
      lat = 0;
      while (!prod_valid && lat < 20) begin
        if (start_ready) sweep_bad++;
        @(negedge clk);
        lat++;
      end
      if (lat != W) sweep_bad++;
      if (prod_out !== ref_mul(4'(i >> 4), 4'(i))) begin
        sweep_bad++;
        $display("FAIL sweep a=%0h b=%0h: got %0h expected %0h",
                 4'(i >> 4), 4'(i), prod_out, ref_mul(4'(i >> 4), 4'(i)));
      end
      @(negedge clk);
      prod_ready = 1'b0;
    end
    chk("sweep_errors", 32'(sweep_bad), 32'd0);

    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      run_mul($sformatf("rnd%0d", i), ra, rb, ref_mul(ra, rb),
              int'($urandom_range(0, 3)));
    end

    // Start pulse during BUSY must be dropped.
    @(negedge clk);
    a_in = 4'd2;
    b_in = 4'd3;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    a_in = 4'd5;
    b_in = 4'd5;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    lat = 2;
    while (!prod_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_pulse_latency", 32'(lat), 32'(W));
    chk("busy_pulse_prod", 32'(prod_out), 32'h06);
    prod_ready = 1'b1;
    @(negedge clk);
    prod_ready = 1'b0;
    @(negedge clk);
    chk("busy_pulse_not_queued", 32'(start_ready), 32'd1);
    run_mul("second_pair", 4'd5, 4'd5, 8'h19, 0);

    run_mul("backpressure", 4'hA, 4'd3, 8'hEE, 10);

    // Async reset in the second BUSY cycle.
    @(negedge clk);
    a_in = 4'd5;
    b_in = 4'hD;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(prod_valid), 32'd0);
    chk("midrst_prod", 32'(prod_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", 32'(start_ready), 32'd1);
    run_mul("after_rst", 4'd7, 4'd7, 8'h31, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
